// File: rtl/draw_sprite_anim.sv
// draw_sprite_anim: sprite overlay on the VGA timing chain with keying, mirroring and animation.
// Position, mirror and frame index are latched on each vsync rising edge.
module draw_sprite_anim #(
  parameter int          WIDTH     = 50,
  parameter int          HEIGHT    = 54,
  parameter int          FRAMES    = 1,
  parameter int          FRAME_DIV = 8,
  parameter int          ROM_LAT   = 1,
  parameter int          ADDR_W    = 12,
  parameter logic [11:0] KEY_COLOR = 12'h848
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [11:0]       hcount_in,
  input  logic [11:0]       vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic [11:0]       x_pos,
  input  logic [11:0]       y_pos,
  input  logic              mirror,
  input  logic              anim_en,
  input  logic [11:0]       rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [11:0]       hcount_out,
  output logic [11:0]       vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out
);
  localparam logic [ADDR_W-1:0] FSIZE = ADDR_W'(WIDTH * HEIGHT);
  localparam int                LAST  = ROM_LAT - 1;

  logic                      vsync_q, mir_q, vs_edge, hit;
  logic [11:0]               x_q, y_q, col, row, col_m;
  logic [3:0]                frame_q, frame_d;
  logic [7:0]                div_q, div_d;
  logic [ROM_LAT-1:0][11:0]  hc_q, vc_q, bg_q;
  logic [ROM_LAT-1:0]        hs_q, vs_q, hb_q, vb_q, hit_q;

  assign vs_edge = vsync_in & ~vsync_q;

  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (vs_edge && anim_en) begin
      div_d   = (div_q == 8'(FRAME_DIV - 1)) ? 8'd0 : div_q + 8'd1;
      frame_d = (div_q != 8'(FRAME_DIV - 1)) ? frame_q :
                (frame_q == 4'(FRAMES - 1)) ? 4'd0 : frame_q + 4'd1;
    end
  end

  // 13-bit compare so a sprite near the right/bottom edge never wraps to column/line 0
  assign hit = ({1'b0, hcount_in} >= {1'b0, x_q}) &&
               ({1'b0, hcount_in} <  {1'b0, x_q} + 13'(WIDTH)) &&
               ({1'b0, vcount_in} >= {1'b0, y_q}) &&
               ({1'b0, vcount_in} <  {1'b0, y_q} + 13'(HEIGHT));

  assign col        = hcount_in - x_q;
  assign row        = vcount_in - y_q;
  assign col_m      = mir_q ? 12'(WIDTH - 1) - col : col;
  assign pixel_addr = ADDR_W'(frame_q) * FSIZE + ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col_m);

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      vsync_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      mir_q      <= 1'b0;
      frame_q    <= '0;
      div_q      <= '0;
      hc_q       <= '0;
      vc_q       <= '0;
      bg_q       <= '0;
      hs_q       <= '0;
      vs_q       <= '0;
      hb_q       <= '0;
      vb_q       <= '0;
      hit_q      <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      vsync_q <= vsync_in;
      frame_q <= frame_d;
      div_q   <= div_d;
      if (vs_edge) begin
        x_q   <= x_pos;
        y_q   <= y_pos;
        mir_q <= mirror;
      end
      hc_q[0]  <= hcount_in;
      vc_q[0]  <= vcount_in;
      bg_q[0]  <= rgb_in;
      hs_q[0]  <= hsync_in;
      vs_q[0]  <= vsync_in;
      hb_q[0]  <= hblnk_in;
      vb_q[0]  <= vblnk_in;
      hit_q[0] <= hit;
      for (int i = 1; i < ROM_LAT; i++) begin
        hc_q[i]  <= hc_q[i-1];
        vc_q[i]  <= vc_q[i-1];
        bg_q[i]  <= bg_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
        hb_q[i]  <= hb_q[i-1];
        vb_q[i]  <= vb_q[i-1];
        hit_q[i] <= hit_q[i-1];
      end
      hcount_out <= hc_q[LAST];
      vcount_out <= vc_q[LAST];
      hsync_out  <= hs_q[LAST];
      vsync_out  <= vs_q[LAST];
      hblnk_out  <= hb_q[LAST];
      vblnk_out  <= vb_q[LAST];
      rgb_out    <= (hb_q[LAST] | vb_q[LAST]) ? 12'h000 :
                    (hit_q[LAST] && rgb_pixel != KEY_COLOR) ? rgb_pixel : bg_q[LAST];
    end
  end
endmodule

// File: tb/tb_draw_sprite_anim.sv
// tb_draw_sprite_anim: randomized scoreboard bench with a frame-level reference model and ROM model.
module tb_draw_sprite_anim;
  localparam int          W = 50, H = 54, NF = 4, FD = 2, RL = 2, AW = 14, L = RL + 1;
  localparam logic [11:0] KEY = 12'h848;

  logic          pclk = 1'b0, reset = 1'b0;
  logic [11:0]   hcount_in = '0, vcount_in = '0, rgb_in = '0, x_pos = '0, y_pos = '0;
  logic          hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic          mirror = 1'b0, anim_en = 1'b0;
  logic [11:0]   rgb_pixel;
  logic [AW-1:0] pixel_addr;
  logic [11:0]   hcount_out, vcount_out, rgb_out;
  logic          hsync_out, vsync_out, hblnk_out, vblnk_out;

  always #5 pclk = ~pclk;

  draw_sprite_anim #(.WIDTH(W), .HEIGHT(H), .FRAMES(NF), .FRAME_DIV(FD), .ROM_LAT(RL),
                     .ADDR_W(AW), .KEY_COLOR(KEY)) dut (
    .pclk(pclk), .reset(reset), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .x_pos(x_pos), .y_pos(y_pos), .mirror(mirror), .anim_en(anim_en),
    .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr), .hcount_out(hcount_out),
    .vcount_out(vcount_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  // ROM: content is the low address bits, except every address = 3 mod 7 holds the key colour
  function automatic logic [11:0] rom(input logic [AW-1:0] a);
    return (int'(a) % 7 == 3) ? KEY : a[11:0];
  endfunction

  logic [AW-1:0] rom_p [RL] = '{default: '0};
  always @(posedge pclk) begin
    rom_p[0] <= pixel_addr;
    for (int i = 1; i < RL; i++) rom_p[i] <= rom_p[i-1];
  end
  assign rgb_pixel = rom(rom_p[RL-1]);

  typedef struct {
    int          due;
    logic [11:0] h, v, rgb;
    logic        hs, vs, hb, vb;
  } exp_t;
  exp_t q[$];

  int cyc = 0, checks = 0, passed = 0;
  int mX = 0, mY = 0, edges = 0;
  bit mM = 0, pvs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  always begin
    exp_t e;
    @(posedge pclk);
    cyc++;
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("rgb_out", 64'(rgb_out), 64'(e.rgb));
      chk("timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
          {e.h, e.v, e.hs, e.vs, e.hb, e.vb});
    end
  end

  task automatic px(input int hh, input int vv, input bit vs = 0, input bit hb = 0, input bit vb = 0);
    int h, v, fr, col, addr;
    bit hit, hsv;
    logic [11:0] bg, rv, er;
    h = hh & 4095;
    v = vv & 4095;
    hsv = 1'($urandom);
    bg  = 12'($urandom);
    @(negedge pclk);
    hcount_in = 12'(h); vcount_in = 12'(v); hsync_in = hsv; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; rgb_in = bg;
    #1;
    fr   = (edges / FD) % NF;
    hit  = (h >= mX) && (h < mX + W) && (v >= mY) && (v < mY + H);
    col  = mM ? W - 1 - (h - mX) : h - mX;
    addr = (fr * W * H + (v - mY) * W + col) % (1 << AW);
    rv   = rom(AW'(addr));
    er   = (hb || vb) ? 12'h000 : (hit && rv != KEY) ? rv : bg;
    if (hit) chk("pixel_addr", 64'(pixel_addr), 64'(addr));
    q.push_back('{due: cyc + L, h: 12'(h), v: 12'(v), rgb: er, hs: hsv, vs: vs, hb: hb, vb: vb});
    @(posedge pclk);
    if (vs && !pvs) begin
      mX = int'(x_pos); mY = int'(y_pos); mM = mirror;
      if (anim_en) edges++;
    end
    pvs = vs;
  endtask

  task automatic vedge();
    px(0, 0, 0);
    px(0, 0, 1);
    px(0, 0, 0);
  endtask

  task automatic near(input int n);
    repeat (n) px(mX - 2 + $urandom_range(0, W + 3), mY - 2 + $urandom_range(0, H + 3),
                  0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge pclk);
    #1 chk("reset_init", {hcount_out, vcount_out, rgb_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
    @(posedge pclk);
    #2 reset = 1'b1;

    x_pos = 12'hFFF; y_pos = 12'hFFF;
    vedge();
    repeat (40) px($urandom_range(0, 4095), $urandom_range(0, 4094), 1'($urandom), 1'($urandom), 1'($urandom));

    x_pos = 100; y_pos = 50; mirror = 0;
    vedge();
    px(100, 50); px(149, 103); px(150, 103); px(99, 50); px(100, 49); px(100, 104);
    px(120, 60, 0, 1, 0); px(120, 60, 0, 0, 1);
    near(60);

    mirror = 1;
    vedge();
    px(100, 50); px(149, 103);
    near(60);

    mirror = 0; anim_en = 1;
    for (int i = 0; i < 10; i++) begin
      vedge();
      px(100, 50); px(149, 103);
    end
    anim_en = 0;
    for (int i = 0; i < 4; i++) begin
      vedge();
      px(100, 50);
    end

    x_pos = 200;
    vedge();
    x_pos = 300;
    repeat (20) px(190 + $urandom_range(0, 130), 60);
    vedge();
    repeat (20) px(190 + $urandom_range(0, 130), 60);
    x_pos = 4090; y_pos = 10;
    vedge();
    repeat (40) px(4000 + $urandom_range(0, 95), 10 + $urandom_range(0, 60));

    repeat (800) begin
      if ($urandom_range(0, 49) == 0) begin
        x_pos = 12'($urandom_range(0, 4095)); y_pos = 12'($urandom_range(0, 4095));
        mirror = 1'($urandom); anim_en = 1'($urandom);
      end
      px(mX - 3 + $urandom_range(0, W + 6), mY - 3 + $urandom_range(0, H + 6),
         $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    @(negedge pclk);
    #2 reset = 1'b0;
    #1 chk("reset_async", {hcount_out, vcount_out, rgb_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
    q.delete();
    mX = 0; mY = 0; mM = 0; edges = 0; pvs = 0;
    vsync_in = 0;
    repeat (2) @(posedge pclk);
    #2 reset = 1'b1;
    near(30);
    x_pos = 20; y_pos = 30; mirror = 1; anim_en = 1;
    vedge();
    near(40);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge pclk);
    #2 chk("drain", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
